// File: rtl/cmdrx.sv
// cmdrx: assembles host bytes into 40-bit SUMP commands and strobes exec_o per command.
// Latency: 1 cycle from the strobe of the last byte of a command (opcode or 4th arg) to exec_o.
// Backpressure: none; every rx_stb_i byte is accepted, back-to-back bytes included.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   rx_stb_i, rx_i    received-byte strobe and byte
//   cmd_o             last complete command {opcode[39:32], argument[31:0]}
//   exec_o            one-cycle strobe, cmd_o just updated
//   busy_o            long command partially received
//   err_o             one-cycle strobe, partial command dropped by timeout
//
// Optional feature macro: LOGIP_CMDRX_TIMEOUT_EN enables the inter-byte timeout
// (TIMEOUT cycles). Without it, err_o is tied low and ARG waits forever.
module cmdrx #(
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_stb_i,
  input  logic [7:0]  rx_i,
  output logic [39:0] cmd_o,
  output logic        exec_o,
  output logic        busy_o,
  output logic        err_o
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("cmdrx: TIMEOUT must be >= 2");
  end

  typedef enum logic {S_IDLE, S_ARG} state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [7:0]  r_op;     // shadow opcode
  logic [31:0] r_arg;    // shadow argument, filled LSB-first
  logic [39:0] r_cmd;
  logic        r_exec;
  logic        r_busy;
  logic        r_err;
  logic        w_expire;

`ifdef LOGIP_CMDRX_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  // r_cnt is 0 in the cycle after an accepted byte, so it holds TIMEOUT-2 in the
  // cycle whose closing edge is the (TIMEOUT-1)th idle edge; firing here makes
  // err_o appear in the cycle after edge N+TIMEOUT-1 for a last byte at edge N.
  // A byte in that same cycle wins, so the strobe gates expiry.
  assign w_expire = (r_state == S_ARG) && !rx_stb_i && (r_cnt == CW'(TIMEOUT - 2));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (rx_stb_i || r_state != S_ARG) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_op    <= 8'h00;
      r_arg   <= 32'h0;
      r_cmd   <= 40'h0;
      r_exec  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_exec <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_stb_i) begin
            if (!rx_i[7]) begin
              r_cmd  <= {rx_i, 32'h0};
              r_exec <= 1'b1;
            end else begin
              r_op    <= rx_i;
              r_arg   <= 32'h0;
              r_idx   <= 2'd0;
              r_state <= S_ARG;
              r_busy  <= 1'b1;
            end
          end
        end
        S_ARG: begin
          if (rx_stb_i) begin
            r_arg[8*r_idx +: 8] <= rx_i;
            if (r_idx == 2'd3) begin
              // Fourth byte goes straight to cmd_o; shadow holds bytes 0..2.
              r_cmd   <= {r_op, rx_i, r_arg[23:0]};
              r_exec  <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end else if (w_expire) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_op    <= 8'h00;
            r_arg   <= 32'h0;
            r_idx   <= 2'd0;
            r_err   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_o  = r_cmd;
  assign exec_o = r_exec;
  assign busy_o = r_busy;
  assign err_o  = r_err;

endmodule

// File: tb/tb_cmdrx.sv
// tb_cmdrx: directed-vector bench for cmdrx with hand-computed expected values.
// Inputs driven 1 ns after posedge, outputs sampled 1 ns after posedge.
// Timeout tests are selected by LOGIP_CMDRX_TIMEOUT_EN (TIMEOUT = 16).
module tb_cmdrx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_stb_i = 1'b0;
  logic [7:0]  rx_i = 8'h00;
  logic [39:0] cmd_o;
  logic        exec_o;
  logic        busy_o;
  logic        err_o;

  int n_cmp = 0;
  int n_bad = 0;

  cmdrx #(.TIMEOUT(16)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rx_stb_i (rx_stb_i),
    .rx_i     (rx_i),
    .cmd_o    (cmd_o),
    .exec_o   (exec_o),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One byte strobe; returns 1 ns after the edge that accepts it.
  task automatic send(input logic [7:0] b);
    rx_stb_i = 1'b1;
    rx_i     = b;
    @(posedge clk_i);
    #1;
    rx_stb_i = 1'b0;
    rx_i     = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".cmd"},  64'(cmd_o),  64'h0);
    chk({tag, ".exec"}, 64'(exec_o), 64'h0);
    chk({tag, ".busy"}, 64'(busy_o), 64'h0);
    chk({tag, ".err"},  64'(err_o),  64'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    idle(3);
    rst_i = 1'b0;
    chk_reset_vals("rst");

    // Two short opcodes back to back
    send(8'h01);
    chk("s1.exec", 64'(exec_o), 64'h1);
    chk("s1.cmd",  64'(cmd_o),  64'h01_0000_0000);
    chk("s1.busy", 64'(busy_o), 64'h0);
    send(8'h02);
    chk("s2.exec", 64'(exec_o), 64'h1);
    chk("s2.cmd",  64'(cmd_o),  64'h02_0000_0000);
    chk("s2.busy", 64'(busy_o), 64'h0);
    idle(1);
    chk("s2.exec_lo", 64'(exec_o), 64'h0);

    // Long command with gaps; cmd_o must hold until completion
    send(8'h80);
    chk("l1.busy0", 64'(busy_o), 64'h1);
    chk("l1.hold0", 64'(cmd_o),  64'h02_0000_0000);
    idle(2);
    send(8'h78);
    chk("l1.busy1", 64'(busy_o), 64'h1);
    chk("l1.exec1", 64'(exec_o), 64'h0);
    idle(3);
    send(8'h56);
    send(8'h34);
    chk("l1.hold3", 64'(cmd_o),  64'h02_0000_0000);
    idle(1);
    send(8'h12);
    chk("l1.exec", 64'(exec_o), 64'h1);
    chk("l1.cmd",  64'(cmd_o),  64'h80_1234_5678);
    chk("l1.busy", 64'(busy_o), 64'h0);

    // Long command then short opcode in the exec_o cycle
    send(8'hC0);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    chk("l2.exec", 64'(exec_o), 64'h1);
    chk("l2.cmd",  64'(cmd_o),  64'hC0_4433_2211);
    send(8'h00);
    chk("l2.exec2", 64'(exec_o), 64'h1);
    chk("l2.cmd2",  64'(cmd_o),  64'h00_0000_0000);
    idle(1);
    chk("l2.exec_lo", 64'(exec_o), 64'h0);

`ifdef LOGIP_CMDRX_TIMEOUT_EN
    // Timeout: last byte at edge N, err_o after edge N+15
    send(8'h81);
    send(8'hAA);
    idle(14);
    chk("to.err_early", 64'(err_o),  64'h0);
    chk("to.busy_early", 64'(busy_o), 64'h1);
    idle(1);
    chk("to.err",  64'(err_o),  64'h1);
    chk("to.busy", 64'(busy_o), 64'h0);
    chk("to.exec", 64'(exec_o), 64'h0);
    chk("to.cmd",  64'(cmd_o),  64'h00_0000_0000);
    idle(1);
    chk("to.err_lo", 64'(err_o), 64'h0);
    send(8'h11);
    chk("to.s.exec", 64'(exec_o), 64'h1);
    chk("to.s.cmd",  64'(cmd_o),  64'h11_0000_0000);

    // Byte in the expiry cycle wins
    send(8'h82);
    send(8'h01);
    idle(14);
    send(8'h02);
    chk("tw.err",  64'(err_o),  64'h0);
    chk("tw.busy", 64'(busy_o), 64'h1);
    send(8'h03);
    send(8'h04);
    chk("tw.exec", 64'(exec_o), 64'h1);
    chk("tw.cmd",  64'(cmd_o),  64'h82_0403_0201);
    chk("tw.err2", 64'(err_o),  64'h0);
`else
    // No timeout: a long gap mid-command is harmless
    send(8'h82);
    send(8'h01);
    idle(5000);
    chk("ng.busy", 64'(busy_o), 64'h1);
    chk("ng.err",  64'(err_o),  64'h0);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    chk("ng.exec", 64'(exec_o), 64'h1);
    chk("ng.cmd",  64'(cmd_o),  64'h82_0403_0201);
`endif

    // Reset mid-command, then a fresh long command
    send(8'h80);
    send(8'hAA);
    send(8'hBB);
    rst_i = 1'b1;
    idle(1);
    chk_reset_vals("mr");
    rst_i = 1'b0;
    idle(1);
    chk_reset_vals("mr2");
    send(8'h80);
    send(8'hDE);
    send(8'hAD);
    send(8'hBE);
    chk("mr.busy", 64'(busy_o), 64'h1);
    send(8'hEF);
    chk("mr.exec", 64'(exec_o), 64'h1);
    chk("mr.cmd",  64'(cmd_o),  64'h80_EFBE_ADDE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
